// File: rtl/mux_sched_pkg.sv
// Shared constants, state encoding and lane-range helper for the
// triangular mux bank select scheduler.
package mux_sched_pkg;

  localparam int NUM_MUX  = 64;
  localparam int SEL_W    = 7;
  localparam int LEN_W    = 8;
  localparam int STRIDE_W = 3;
  localparam int ACC_W    = 12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Lane i of the triangular bank has NUM_MUX-i+1 inputs.
  function automatic logic [ACC_W-1:0] lane_max(input int unsigned i);
    return ACC_W'(NUM_MUX - i);
  endfunction

endpackage

// File: rtl/mux_sel_lane_clamp.sv
// One lane of the select generator: applies the lane's diagonal offset
// and clamps the result to the lane's legal select range.
module mux_sel_lane_clamp
  import mux_sched_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_mode,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_clamped
);

  localparam logic [ACC_W-1:0] LANE_OFF = ACC_W'(LANE);
  localparam logic [ACC_W-1:0] LANE_MAX = lane_max(LANE);

  logic [ACC_W-1:0] w_raw;

  // ACC_W leaves headroom for acc + NUM_MUX-1, so the compare never sees a wrapped value.
  assign w_raw     = i_acc + (i_mode ? LANE_OFF : '0);
  assign o_clamped = (w_raw > LANE_MAX);
  assign o_sel     = o_clamped ? LANE_MAX[SEL_W-1:0] : w_raw[SEL_W-1:0];

endmodule

// File: rtl/mux_bank_sel_scheduler.sv
// Accepts one (base, stride, length, mode) command and streams clamped
// select vectors for the 64-lane triangular mux bank, one per downstream beat.
module mux_bank_sel_scheduler
  import mux_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [SEL_W-1:0]           cmd_base,
  input  logic [STRIDE_W-1:0]        cmd_stride,
  input  logic [LEN_W-1:0]           cmd_len,
  input  logic                       cmd_mode,
  input  logic                       abort,
  output logic [NUM_MUX*SEL_W-1:0]   sel_vec,
  output logic                       sel_valid,
  input  logic                       sel_ready,
  output logic                       sel_clamped,
  output logic                       busy,
  output logic                       done
);

  state_t                r_state;
  logic [ACC_W-1:0]      r_acc;
  logic [STRIDE_W-1:0]   r_stride;
  logic [LEN_W-1:0]      r_remaining;
  logic                  r_mode;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_beat;
  logic [SEL_W-1:0]      w_sel [NUM_MUX];
  logic [NUM_MUX-1:0]    w_clamp;

  // Every output is forced low while rst is held, even before the reset edge lands.
  assign cmd_ready = (r_state == IDLE) && !rst;
  assign sel_valid = (r_state == RUN) && !rst;
  assign busy      = (r_state != IDLE) && !rst;
  assign done      = r_done && !rst;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_beat    = sel_valid && sel_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_mode      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc       <= ACC_W'(cmd_base);
            r_stride    <= cmd_stride;
            r_mode      <= cmd_mode;
            r_remaining <= cmd_len;
            if (cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_beat) begin
            r_acc       <= r_acc + ACC_W'(r_stride);
            r_remaining <= r_remaining - 1'b1;
          end
          // A beat taken alongside abort is delivered, but the command ends without done.
          if (abort) begin
            r_state <= IDLE;
          end else if (w_beat && (r_remaining == LEN_W'(1))) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_MUX; g++) begin : g_lane
    mux_sel_lane_clamp #(
      .LANE(g)
    ) u_lane (
      .i_acc    (r_acc),
      .i_mode   (r_mode),
      .o_sel    (w_sel[g]),
      .o_clamped(w_clamp[g])
    );

    assign sel_vec[g*SEL_W +: SEL_W] = sel_valid ? w_sel[g] : '0;
  end

  assign sel_clamped = sel_valid && (|w_clamp);

endmodule

// File: tb/tb_mux_bank_sel_scheduler.sv
// Directed bench for mux_bank_sel_scheduler: table of short commands plus
// hand-written backpressure, zero-length, abort, reset and saturation sequences.
module tb_mux_bank_sel_scheduler;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [6:0]   cmd_base;
  logic [2:0]   cmd_stride;
  logic [7:0]   cmd_len;
  logic         cmd_mode;
  logic         abort;
  logic [447:0] sel_vec;
  logic         sel_valid;
  logic         sel_ready;
  logic         sel_clamped;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  mux_bank_sel_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_len    (cmd_len),
    .cmd_mode   (cmd_mode),
    .abort      (abort),
    .sel_vec    (sel_vec),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_clamped(sel_clamped),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [6:0]      base;
    logic [2:0]      stride;
    logic [7:0]      len;
    logic            mode;
    logic [5:0]      lane;
    logic [3:0][6:0] exp;
    logic            clamp;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input int b, input int s, input int l, input int m,
                              input int ln, input int e0, input int e1,
                              input int e2, input int e3, input int c);
    vec_t v;
    v.base   = 7'(b);
    v.stride = 3'(s);
    v.len    = 8'(l);
    v.mode   = 1'(m);
    v.lane   = 6'(ln);
    v.exp[0] = 7'(e0);
    v.exp[1] = 7'(e1);
    v.exp[2] = 7'(e2);
    v.exp[3] = 7'(e3);
    v.clamp  = 1'(c);
    return v;
  endfunction

  function automatic logic [6:0] lane_of(input int l);
    return sel_vec[l*7 +: 7];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input int b, input int s, input int l, input int m);
    cmd_valid  = 1'b1;
    cmd_base   = 7'(b);
    cmd_stride = 3'(s);
    cmd_len    = 8'(l);
    cmd_mode   = 1'(m);
  endtask

  // Entered and left at a negedge; sel_ready held high throughout.
  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_ready", idx), 32'(cmd_ready), 32'd1);
    drive_cmd(int'(v.base), int'(v.stride), int'(v.len), int'(v.mode));
    sel_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_base  = 7'h7f;
    for (int k = 0; k < int'(v.len); k++) begin
      chk($sformatf("v%0d_b%0d_valid", idx, k), 32'(sel_valid), 32'd1);
      chk($sformatf("v%0d_b%0d_lane%0d", idx, k, v.lane), 32'(lane_of(int'(v.lane))), 32'(v.exp[k]));
      chk($sformatf("v%0d_b%0d_clamped", idx, k), 32'(sel_clamped), 32'(v.clamp));
      @(negedge clk);
    end
    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_valid_end", idx), 32'(sel_valid), 32'd0);
    chk($sformatf("v%0d_vec_end", idx), 32'(sel_vec == '0), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
  endtask

  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int beats;
  logic [447:0] exp_sat;
  logic [447:0] held;

  initial begin
    tbl[0]  = mk(10, 1, 3, 0, 63,  1,  1,  1, 0, 1);
    tbl[1]  = mk(10, 1, 3, 0, 54, 10, 10, 10, 0, 1);
    tbl[2]  = mk(10, 1, 3, 0,  0, 10, 11, 12, 0, 1);
    tbl[3]  = mk(10, 1, 3, 0, 53, 10, 11, 11, 0, 1);
    tbl[4]  = mk( 0, 0, 1, 1,  0,  0,  0,  0, 0, 1);
    tbl[5]  = mk( 0, 0, 1, 1, 32, 32,  0,  0, 0, 1);
    tbl[6]  = mk( 0, 0, 1, 1, 40, 24,  0,  0, 0, 1);
    tbl[7]  = mk( 0, 0, 1, 1, 63,  1,  0,  0, 0, 1);
    tbl[8]  = mk( 0, 0, 2, 0, 63,  0,  0,  0, 0, 0);
    tbl[9]  = mk( 1, 0, 1, 0, 63,  1,  0,  0, 0, 0);
    tbl[10] = mk( 2, 0, 1, 0, 63,  1,  0,  0, 0, 1);
    tbl[11] = mk(64, 0, 1, 0,  0, 64,  0,  0, 0, 1);
    tbl[12] = mk(64, 0, 1, 0,  1, 63,  0,  0, 0, 1);
    tbl[13] = mk( 5, 2, 2, 1, 10, 15, 17,  0, 0, 1);
    tbl[14] = mk( 3, 3, 4, 0, 60,  3,  4,  4, 4, 1);

    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0;
    cmd_len = '0; cmd_mode = 1'b0; abort = 1'b0; sel_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel_vec_zero", 32'(sel_vec == '0), 32'd1);
    chk("rst_clamped", 32'(sel_clamped), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 15; i++) run_vec(tbl[i], i);

    // Backpressure: 4 beats through the ready pattern 1,0,0,1,1,0,1
    drive_cmd(5, 2, 4, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_cmd_ready_run", 32'(cmd_ready), 32'd0);
    beats = 0;
    for (int c = 0; c < 7; c++) begin
      sel_ready = 1'(pat[c]);
      held = sel_vec;
      chk($sformatf("bp_c%0d_valid", c), 32'(sel_valid), 32'd1);
      chk($sformatf("bp_c%0d_lane0", c), 32'(lane_of(0)), 32'(5 + 2 * beats));
      if (pat[c] == 0) begin
        @(negedge clk);
        chk($sformatf("bp_c%0d_stable", c), 32'(sel_vec == held), 32'd1);
      end else begin
        beats++;
        @(negedge clk);
      end
    end
    sel_ready = 1'b1;
    chk("bp_beats", 32'(beats), 32'd4);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_valid_end", 32'(sel_valid), 32'd0);
    @(negedge clk);

    // Zero length, then a command accepted in the done cycle
    drive_cmd(0, 0, 0, 0);
    @(negedge clk);
    chk("zl_valid", 32'(sel_valid), 32'd0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_cmd_ready", 32'(cmd_ready), 32'd1);
    drive_cmd(64, 0, 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_valid", 32'(sel_valid), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_lane0", 32'(lane_of(0)), 32'd64);
    chk("b2b_lane1", 32'(lane_of(1)), 32'd63);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    @(negedge clk);

    // Abort after three beats
    drive_cmd(0, 1, 10, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ab_b%0d_lane0", k), 32'(lane_of(0)), 32'(k));
      @(negedge clk);
    end
    abort = 1'b1;
    sel_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", 32'(sel_valid), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    // Abort in IDLE is ignored and the simultaneous command is taken
    abort = 1'b1;
    drive_cmd(3, 0, 1, 0);
    @(negedge clk);
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("ab_idle_valid", 32'(sel_valid), 32'd1);
    chk("ab_idle_lane0", 32'(lane_of(0)), 32'd3);
    sel_ready = 1'b1;
    @(negedge clk);
    chk("ab_idle_done", 32'(done), 32'd1);
    @(negedge clk);

    // Reset mid-run
    drive_cmd(20, 1, 10, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_rst_valid", 32'(sel_valid), 32'd0);
    chk("mr_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mr_rst_vec", 32'(sel_vec == '0), 32'd1);
    @(negedge clk);
    chk("mr_rst_busy", 32'(busy), 32'd0);
    chk("mr_rst_clamped", 32'(sel_clamped), 32'd0);
    chk("mr_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_post_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("mr_post_valid", 32'(sel_valid), 32'd0);
    chk("mr_post_done", 32'(done), 32'd0);

    // Saturation: every lane pinned at 64-i for all 255 beats
    for (int i = 0; i < 64; i++) exp_sat[i*7 +: 7] = 7'(64 - i);
    drive_cmd(64, 7, 255, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 255; k++) begin
      chk($sformatf("sat_b%0d_vec", k), 32'(sel_valid && (sel_vec == exp_sat)), 32'd1);
      chk($sformatf("sat_b%0d_clamped", k), 32'(sel_clamped), 32'd1);
      @(negedge clk);
    end
    chk("sat_done", 32'(done), 32'd1);
    chk("sat_valid_end", 32'(sel_valid), 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
